// File: rtl/ctrl_encode_def.sv
// Shared control encodings for the RV32IM decode/control stage.
package ctrl_encode_def;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_M    = 7'b0000001;

  localparam logic [5:0] EXT_CTRL_ITYPE_SHAMT = 6'b100000;
  localparam logic [5:0] EXT_CTRL_ITYPE       = 6'b010000;
  localparam logic [5:0] EXT_CTRL_STYPE       = 6'b001000;
  localparam logic [5:0] EXT_CTRL_BTYPE       = 6'b000100;
  localparam logic [5:0] EXT_CTRL_UTYPE       = 6'b000010;
  localparam logic [5:0] EXT_CTRL_JTYPE       = 6'b000001;

  localparam logic [1:0] WDSel_FromALU = 2'b00;
  localparam logic [1:0] WDSel_FromMEM = 2'b01;
  localparam logic [1:0] WDSel_FromPC  = 2'b10;

  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b100;

  localparam logic [4:0] ALUOp_NOP    = 5'd0;
  localparam logic [4:0] ALUOp_LUI    = 5'd1;
  localparam logic [4:0] ALUOp_AUIPC  = 5'd2;
  localparam logic [4:0] ALUOp_ADD    = 5'd3;
  localparam logic [4:0] ALUOp_SUB    = 5'd4;
  localparam logic [4:0] ALUOp_BNE    = 5'd5;
  localparam logic [4:0] ALUOp_BLT    = 5'd6;
  localparam logic [4:0] ALUOp_BGE    = 5'd7;
  localparam logic [4:0] ALUOp_BLTU   = 5'd8;
  localparam logic [4:0] ALUOp_BGEU   = 5'd9;
  localparam logic [4:0] ALUOp_SLT    = 5'd10;
  localparam logic [4:0] ALUOp_SLTU   = 5'd11;
  localparam logic [4:0] ALUOp_XOR    = 5'd12;
  localparam logic [4:0] ALUOp_OR     = 5'd13;
  localparam logic [4:0] ALUOp_AND    = 5'd14;
  localparam logic [4:0] ALUOp_SLL    = 5'd15;
  localparam logic [4:0] ALUOp_SRL    = 5'd16;
  localparam logic [4:0] ALUOp_SRA    = 5'd17;
  // M ops are laid out in funct3 order so ALUOp_MUL + funct3 selects the op.
  localparam logic [4:0] ALUOp_MUL    = 5'd18;
  localparam logic [4:0] ALUOp_MULH   = 5'd19;
  localparam logic [4:0] ALUOp_MULHSU = 5'd20;
  localparam logic [4:0] ALUOp_MULHU  = 5'd21;
  localparam logic [4:0] ALUOp_DIV    = 5'd22;
  localparam logic [4:0] ALUOp_DIVU   = 5'd23;
  localparam logic [4:0] ALUOp_REM    = 5'd24;
  localparam logic [4:0] ALUOp_REMU   = 5'd25;

  localparam logic [2:0] dm_word              = 3'b000;
  localparam logic [2:0] dm_halfword          = 3'b001;
  localparam logic [2:0] dm_halfword_unsigned = 3'b010;
  localparam logic [2:0] dm_byte              = 3'b011;
  localparam logic [2:0] dm_byte_unsigned     = 3'b100;

  typedef enum logic {
    LAT_MUL = 1'b0,
    LAT_DIV = 1'b1
  } lat_sel_e;

  typedef struct packed {
    logic       RegWrite;
    logic       MemWrite;
    logic       ALUSrc;
    logic [5:0] EXTOp;
    logic [4:0] ALUOp;
    logic [2:0] NPCOp;
    logic [1:0] WDSel;
    logic [2:0] dm_ctrl;
  } ctrl_bundle_t;

  function automatic logic [4:0] alu_rr(input logic [2:0] f3);
    case (f3)
      3'b000:  alu_rr = ALUOp_ADD;
      3'b001:  alu_rr = ALUOp_SLL;
      3'b010:  alu_rr = ALUOp_SLT;
      3'b011:  alu_rr = ALUOp_SLTU;
      3'b100:  alu_rr = ALUOp_XOR;
      3'b101:  alu_rr = ALUOp_SRL;
      3'b110:  alu_rr = ALUOp_OR;
      default: alu_rr = ALUOp_AND;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32I(M) instruction decoder.
module ctrl_decode
  import ctrl_encode_def::*;
#(
  parameter int unsigned EN_M = 1
) (
  input  logic         id_valid,
  input  logic [6:0]   id_Op,
  input  logic [2:0]   id_Funct3,
  input  logic [6:0]   id_Funct7,
  output ctrl_bundle_t bundle,
  output logic         illegal,
  output logic         m_op,
  output lat_sel_e     lat_sel,
  output logic         uses_rs1,
  output logic         uses_rs2
);

  ctrl_bundle_t b;
  logic         ok;
  logic         m;
  lat_sel_e     ls;
  logic         r1;
  logic         r2;

  always_comb begin
    b  = '0;
    ok = 1'b0;
    m  = 1'b0;
    ls = LAT_MUL;
    r1 = 1'b0;
    r2 = 1'b0;
    case (id_Op)
      OP_R: begin
        r1 = 1'b1;
        r2 = 1'b1;
        b.RegWrite = 1'b1;
        if (id_Funct7 == F7_BASE) begin
          ok = 1'b1;
          b.ALUOp = alu_rr(id_Funct3);
        end else if (id_Funct7 == F7_ALT && (id_Funct3 == 3'b000 || id_Funct3 == 3'b101)) begin
          ok = 1'b1;
          b.ALUOp = (id_Funct3 == 3'b000) ? ALUOp_SUB : ALUOp_SRA;
        end else if (EN_M != 0 && id_Funct7 == F7_M) begin
          ok = 1'b1;
          m  = 1'b1;
          ls = id_Funct3[2] ? LAT_DIV : LAT_MUL;
          b.ALUOp = ALUOp_MUL + {2'b00, id_Funct3};
        end
      end
      OP_I: begin
        r1 = 1'b1;
        b.RegWrite = 1'b1;
        b.ALUSrc   = 1'b1;
        b.EXTOp    = EXT_CTRL_ITYPE;
        b.ALUOp    = alu_rr(id_Funct3);
        case (id_Funct3)
          3'b001: begin
            ok = (id_Funct7 == F7_BASE);
            b.EXTOp = EXT_CTRL_ITYPE_SHAMT;
          end
          3'b101: begin
            ok = (id_Funct7 == F7_BASE) || (id_Funct7 == F7_ALT);
            b.EXTOp = EXT_CTRL_ITYPE_SHAMT;
            if (id_Funct7 == F7_ALT) b.ALUOp = ALUOp_SRA;
          end
          default: ok = 1'b1;
        endcase
      end
      OP_LOAD: begin
        r1 = 1'b1;
        b.RegWrite = 1'b1;
        b.ALUSrc   = 1'b1;
        b.EXTOp    = EXT_CTRL_ITYPE;
        b.ALUOp    = ALUOp_ADD;
        b.WDSel    = WDSel_FromMEM;
        ok = 1'b1;
        case (id_Funct3)
          3'b000:  b.dm_ctrl = dm_byte;
          3'b001:  b.dm_ctrl = dm_halfword;
          3'b010:  b.dm_ctrl = dm_word;
          3'b100:  b.dm_ctrl = dm_byte_unsigned;
          3'b101:  b.dm_ctrl = dm_halfword_unsigned;
          default: ok = 1'b0;
        endcase
      end
      OP_STORE: begin
        r1 = 1'b1;
        r2 = 1'b1;
        b.MemWrite = 1'b1;
        b.ALUSrc   = 1'b1;
        b.EXTOp    = EXT_CTRL_STYPE;
        b.ALUOp    = ALUOp_ADD;
        ok = 1'b1;
        case (id_Funct3)
          3'b000:  b.dm_ctrl = dm_byte;
          3'b001:  b.dm_ctrl = dm_halfword;
          3'b010:  b.dm_ctrl = dm_word;
          default: ok = 1'b0;
        endcase
      end
      OP_BRANCH: begin
        r1 = 1'b1;
        r2 = 1'b1;
        b.EXTOp = EXT_CTRL_BTYPE;
        b.NPCOp = NPC_BRANCH;
        ok = 1'b1;
        case (id_Funct3)
          3'b000:  b.ALUOp = ALUOp_SUB;
          3'b001:  b.ALUOp = ALUOp_BNE;
          3'b100:  b.ALUOp = ALUOp_BLT;
          3'b101:  b.ALUOp = ALUOp_BGE;
          3'b110:  b.ALUOp = ALUOp_BLTU;
          3'b111:  b.ALUOp = ALUOp_BGEU;
          default: ok = 1'b0;
        endcase
      end
      OP_JAL: begin
        ok = 1'b1;
        b.RegWrite = 1'b1;
        b.EXTOp    = EXT_CTRL_JTYPE;
        b.NPCOp    = NPC_JUMP;
        b.WDSel    = WDSel_FromPC;
      end
      OP_JALR: begin
        ok = (id_Funct3 == 3'b000);
        r1 = 1'b1;
        b.RegWrite = 1'b1;
        b.ALUSrc   = 1'b1;
        b.EXTOp    = EXT_CTRL_ITYPE;
        b.ALUOp    = ALUOp_ADD;
        b.NPCOp    = NPC_JALR;
        b.WDSel    = WDSel_FromPC;
      end
      OP_LUI: begin
        ok = 1'b1;
        b.RegWrite = 1'b1;
        b.ALUSrc   = 1'b1;
        b.EXTOp    = EXT_CTRL_UTYPE;
        b.ALUOp    = ALUOp_LUI;
      end
      OP_AUIPC: begin
        ok = 1'b1;
        b.RegWrite = 1'b1;
        b.ALUSrc   = 1'b1;
        b.EXTOp    = EXT_CTRL_UTYPE;
        b.ALUOp    = ALUOp_AUIPC;
      end
      default: ok = 1'b0;
    endcase
    // Fields are filled optimistically above; scrub everything for bubbles and illegal encodings.
    if (!id_valid || !ok) begin
      b  = '0;
      m  = 1'b0;
      ls = LAT_MUL;
      r1 = 1'b0;
      r2 = 1'b0;
    end
  end

  always_comb begin
    bundle   = b;
    illegal  = id_valid && !ok;
    m_op     = m;
    lat_sel  = ls;
    uses_rs1 = r1;
    uses_rs2 = r2;
  end

endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX control register with load-use, M-op occupancy and flush handling.
module ctrl_pipe
  import ctrl_encode_def::*;
#(
  parameter int unsigned MUL_LAT = 1,
  parameter int unsigned DIV_LAT = 32,
  parameter int unsigned EN_M    = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       id_valid,
  input  logic [6:0] id_Op,
  input  logic [2:0] id_Funct3,
  input  logic [6:0] id_Funct7,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_rd,
  input  logic       flush,
  output logic       stall,
  output logic       ex_valid,
  output logic [4:0] ex_rd,
  output logic       ex_RegWrite,
  output logic       ex_MemWrite,
  output logic       ex_ALUSrc,
  output logic [5:0] ex_EXTOp,
  output logic [4:0] ex_ALUOp,
  output logic [2:0] ex_NPCOp,
  output logic [1:0] ex_WDSel,
  output logic [2:0] ex_dm_ctrl,
  output logic       mdu_start,
  output logic       mdu_busy,
  output logic       illegal
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  ctrl_bundle_t     dec_b;
  logic             dec_ill;
  logic             dec_m;
  lat_sel_e         dec_ls;
  logic             dec_r1;
  logic             dec_r2;
  ctrl_bundle_t     ex_q;
  logic [CNT_W-1:0] cnt;
  logic             lu;

  ctrl_decode #(
    .EN_M(EN_M)
  ) u_decode (
    .id_valid (id_valid),
    .id_Op    (id_Op),
    .id_Funct3(id_Funct3),
    .id_Funct7(id_Funct7),
    .bundle   (dec_b),
    .illegal  (dec_ill),
    .m_op     (dec_m),
    .lat_sel  (dec_ls),
    .uses_rs1 (dec_r1),
    .uses_rs2 (dec_r2)
  );

  always_comb begin
    mdu_busy = (cnt != '0);
    lu = ex_valid && (ex_q.WDSel == WDSel_FromMEM) && (ex_rd != '0) && id_valid &&
         ((dec_r1 && ex_rd == id_rs1) || (dec_r2 && ex_rd == id_rs2));
    stall = mdu_busy || lu;
  end

  // Reset and flush both leave a clean bubble, so they share one branch.
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      ex_q      <= '0;
      ex_valid  <= 1'b0;
      ex_rd     <= '0;
      mdu_start <= 1'b0;
      illegal   <= 1'b0;
      cnt       <= '0;
    end else if (mdu_busy) begin
      cnt       <= cnt - CNT_W'(1);
      mdu_start <= 1'b0;
    end else if (lu) begin
      ex_q      <= '0;
      ex_valid  <= 1'b0;
      ex_rd     <= '0;
      mdu_start <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      ex_q      <= dec_b;
      ex_valid  <= id_valid;
      ex_rd     <= (id_valid && !dec_ill) ? id_rd : '0;
      mdu_start <= dec_m;
      illegal   <= dec_ill;
      cnt       <= dec_m ? ((dec_ls == LAT_DIV) ? DIV_LOAD : MUL_LOAD) : '0;
    end
  end

  always_comb begin
    ex_RegWrite = ex_q.RegWrite;
    ex_MemWrite = ex_q.MemWrite;
    ex_ALUSrc   = ex_q.ALUSrc;
    ex_EXTOp    = ex_q.EXTOp;
    ex_ALUOp    = ex_q.ALUOp;
    ex_NPCOp    = ex_q.NPCOp;
    ex_WDSel    = ex_q.WDSel;
    ex_dm_ctrl  = ex_q.dm_ctrl;
  end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Registered decode/control stage for the pipelined RV32IM core.
- Decodes the ID-stage instruction into the standard control bundle and latches it into the ID/EX control register.
- Detects load-use hazards and inserts bubbles; applies branch/jump flushes.
- Holds the pipeline for a parametrised number of cycles while a multi-cycle M-extension operation occupies EX, and flags illegal encodings.

Parameters:
- MUL_LAT, 1, cycles a mul/mulh/mulhsu/mulhu occupies EX (≥1).
- DIV_LAT, 32, cycles a div/divu/rem/remu occupies EX (≥1).
- EN_M, 1, 1 = RV32M decoded; 0 = M encodings decode as illegal.

Ports:
- clk, input, 1, clock, rising edge.
- rstn, input, 1, synchronous active-low reset.
- id_valid, input, 1, ID holds a real instruction.
- id_Op, input, 7, opcode.
- id_Funct3, input, 3, funct3.
- id_Funct7, input, 7, funct7.
- id_rs1, input, 5, rs1 index.
- id_rs2, input, 5, rs2 index.
- id_rd, input, 5, rd index.
- flush, input, 1, taken branch/jump resolved in EX; kill ID.
- stall, output, 1, hold PC and IF/ID.
- ex_valid, output, 1, EX control register holds a live instruction.
- ex_rd, output, 5, EX destination.
- ex_RegWrite, ex_MemWrite, ex_ALUSrc, output, 1 each, registered control.
- ex_EXTOp, output, 6, registered control.
- ex_ALUOp, output, 5, registered control.
- ex_NPCOp, output, 3, registered control.
- ex_WDSel, output, 2, registered control.
- ex_dm_ctrl, output, 3, registered control.
- mdu_start, output, 1, one-cycle pulse when an M op enters EX.
- mdu_busy, output, 1, M op still occupying EX.
- illegal, output, 1, registered; EX instruction had an unsupported encoding.

Behaviour:
- Reset: when rstn=0 at a clock edge, all ex_* outputs, ex_valid, mdu_start, illegal, and the busy counter are cleared to 0. stall is combinational and therefore 0 while the register state is cleared.
- Decode:
  - Combinational and one-hot per instruction.
  - Instruction set: RV32I R/I/load/store/branch/jal/jalr/lui/auipc, plus RV32M when EN_M=1.
  - Shift-immediate instructions require funct7 = 0000000 (srai: 0100000).
  - Bundle encodings are taken from the shared package.
  - Any other encoding with id_valid=1 is illegal: the bundle is all-zero (no RegWrite/MemWrite) and the illegal bit is set.
- Latency: decoded bundle appears on ex_* one cycle after acceptance.
- Load-use hazard (lu):
  - lu = ex_valid & ex_WDSel==01 & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2 where that operand is used).
  - rs2 is unused for I/load/U/J; rs1 is unused for U/J.
- M op occupancy:
  - On entry to EX, the counter loads LAT-1 (MUL_LAT or DIV_LAT) and mdu_start pulses.
  - mdu_busy = counter≠0.
  - Counter decrements each cycle to 0.
  - LAT=1 yields no busy cycles.
- stall = mdu_busy | lu.
- Per-edge priority:
  1. !rstn: clear all state.
  2. flush: EX register ← bubble (ex_valid=0, bundle 0); counter ← 0; ID instruction discarded.
  3. mdu_busy: EX register holds; ID held via stall.
  4. lu: EX register ← bubble; ID held.
  5. Otherwise: EX register ← decoded ID (bubble if !id_valid).
- Simultaneous flush and busy: flush wins; the busy operation is aborted.
- Simultaneous lu and busy: busy wins; lu is re-evaluated after the counter releases.
- ex_rd=0 never triggers lu.
- A bubble never sets illegal, mdu_start, or write enables.

Decomposition:
- Package ctrl_encode_def holds:
  - opcode constants;
  - EXT_CTRL_* one-hot (ITYPE_SHAMT 100000 … JTYPE 000001);
  - WDSel_* (ALU 00, MEM 01, PC 10);
  - NPC_* (PLUS4 000, BRANCH 001, JUMP 010, JALR 100);
  - ALUOp codes;
  - dm_ctrl codes.
- One sub-module: ctrl_decode, the purely combinational instruction → bundle + illegal + m_op + lat_sel + uses_rs1/uses_rs2 decoder.
- ctrl_pipe owns the registers, hazard logic, and counter.

Test Plan:
- Reset mid-stream: drive add then hold rstn=0 for 1 edge → all ex_* = 0, stall = 0 on the next cycle.
- lw x5,0(x1) followed by add x6,x5,x2 → stall=1 for exactly one cycle, a bubble with ex_valid=0, then add appears with ex_RegWrite=1 and ex_WDSel=00. Repeat with rd=x0 → no stall.
- div x3,x4,x5 with DIV_LAT=32 and a following addi → mdu_start pulses once, then stall=1 for 31 cycles; addi reaches EX on cycle 33. With MUL_LAT=1, mul → no stall.
- flush=1 during div busy at cycle 5 → counter cleared, ex_valid=0 next cycle, stall=0.
- Opcode 0110011 with funct7=0000001 and EN_M=0, and srai with funct7=0000001 → illegal=1, ex_RegWrite=0, ex_MemWrite=0.
- sw then bne then jal then jalr back-to-back, no hazards → EXTOp/NPCOp show 001000/000, 000100/001, 000001/010, 010000/100 on successive cycles.
